// File: rtl/voice_seq_tx_pkg.sv
// Shared audio-path constants: the "None" voice code,
// sequencer state encoding and default 50 MHz timing.
package voice_seq_tx_pkg;

  localparam logic [4:0] NONE_CODE = 5'b01000;

  localparam int DEF_UNIT_CYC    = 10000;
  localparam int DEF_START_CYC   = 250000;
  localparam int DEF_ARM_CYC     = 1000;
  localparam int DEF_TIMEOUT_CYC = 100000000;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SEL       = 3'd1;
  localparam logic [2:0] S_START_LO  = 3'd2;
  localparam logic [2:0] S_BIT_HI    = 3'd3;
  localparam logic [2:0] S_BIT_LO    = 3'd4;
  localparam logic [2:0] S_ARM       = 3'd5;
  localparam logic [2:0] S_WAIT_BUSY = 3'd6;
  localparam logic [2:0] S_FIN       = 3'd7;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One counter width covers every phase and wait length.
  function automatic int cnt_w(input int start_cyc, input int unit_cyc,
                               input int arm_cyc, input int to_cyc);
    return $clog2(max_int(max_int(start_cyc, to_cyc),
                          max_int(3 * unit_cyc, arm_cyc)) + 1);
  endfunction

endpackage

// File: rtl/voice_seq_tx_ow_bit_tx.sv
// One-wire byte transmitter: start-low condition, then
// eight LSB-first bits coded as 3:1 / 1:3 high:low units.
module ow_bit_tx
  import voice_seq_tx_pkg::*;
#(
  parameter int UNIT_CYC  = DEF_UNIT_CYC,
  parameter int START_CYC = DEF_START_CYC,
  parameter int CW        = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic [7:0] byte_in,
  output logic       voice_data,
  output logic       byte_done
);

  localparam logic [CW-1:0] START_LAST = CW'(START_CYC - 1);
  localparam logic [CW-1:0] SHORT_LAST = CW'(UNIT_CYC - 1);
  localparam logic [CW-1:0] LONG_LAST  = CW'(3 * UNIT_CYC - 1);

  logic [2:0]    phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    sh_q, sh_d;
  logic [2:0]    nbit_q, nbit_d;
  logic          vd_q, vd_d;
  logic [CW-1:0] hi_last, lo_last;

  // Phase sequencing; the counter restarts at every phase edge.
  always_comb begin
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    nbit_d    = nbit_q;
    vd_d      = vd_q;
    byte_done = 1'b0;
    hi_last   = sh_q[0] ? LONG_LAST : SHORT_LAST;
    lo_last   = sh_q[0] ? SHORT_LAST : LONG_LAST;
    unique case (phase_q)
      S_IDLE: begin
        if (go) begin
          phase_d = S_START_LO;
          cnt_d   = '0;
          sh_d    = byte_in;
          nbit_d  = '0;
          vd_d    = 1'b0;
        end
      end
      S_START_LO: begin
        if (cnt_q == START_LAST) begin
          phase_d = S_BIT_HI;
          cnt_d   = '0;
          vd_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_BIT_HI: begin
        if (cnt_q == hi_last) begin
          phase_d = S_BIT_LO;
          cnt_d   = '0;
          vd_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_BIT_LO: begin
        if (cnt_q == lo_last) begin
          cnt_d = '0;
          vd_d  = 1'b1;
          if (nbit_q == 3'd7) begin
            phase_d   = S_IDLE;
            byte_done = 1'b1;
          end else begin
            phase_d = S_BIT_HI;
            sh_d    = {1'b0, sh_q[7:1]};
            nbit_d  = nbit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        phase_d = S_IDLE;
        vd_d    = 1'b1;
      end
    endcase
  end

  // Waveform state; the line idles high out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= S_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      nbit_q  <= '0;
      vd_q    <= 1'b1;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      nbit_q  <= nbit_d;
      vd_q    <= vd_d;
    end
  end

  assign voice_data = vd_q;

endmodule

// File: rtl/voice_seq_tx.sv
// Announcement sequencer: sends up to four voice codes to
// the playback chip, pacing each on the chip's busy line.
module voice_seq_tx
  import voice_seq_tx_pkg::*;
#(
  parameter int         UNIT_CYC    = DEF_UNIT_CYC,
  parameter int         START_CYC   = DEF_START_CYC,
  parameter int         ARM_CYC     = DEF_ARM_CYC,
  parameter int         TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter logic [4:0] SKIP_CODE   = NONE_CODE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] code0,
  input  logic [4:0] code1,
  input  logic [4:0] code2,
  input  logic [4:0] code3,
  output logic       ready,
  output logic       voice_data,
  input  logic       busy_n,
  output logic       done,
  output logic       timeout
);

  localparam int CW = cnt_w(START_CYC, UNIT_CYC, ARM_CYC, TIMEOUT_CYC);
  localparam logic [CW-1:0] ARM_LAST = CW'(ARM_CYC - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYC - 1);

  logic [2:0]      state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [3:0][4:0] codes_q, codes_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            timeout_q, timeout_d;
  logic            busy_m_q, busy_s_q;
  logic [4:0]      cur_code;
  logic            go;
  logic            byte_done;

  assign cur_code = codes_q[idx_q[1:0]];
  assign go = (state_q == S_SEL) && (idx_q != 3'd4) &&
              (cur_code != SKIP_CODE);

  ow_bit_tx #(
    .UNIT_CYC  (UNIT_CYC),
    .START_CYC (START_CYC),
    .CW        (CW)
  ) u_ow (
    .clk        (clk),
    .rst        (rst),
    .go         (go),
    .byte_in    ({3'b000, cur_code}),
    .voice_data (voice_data),
    .byte_done  (byte_done)
  );

  // Two-flop synchronizer for the chip's asynchronous busy line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_m_q <= 1'b1;
      busy_s_q <= 1'b1;
    end else begin
      busy_m_q <= busy_n;
      busy_s_q <= busy_m_q;
    end
  end

  // Slot walk, post-frame arm delay and bounded busy wait.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    codes_d   = codes_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          codes_d   = {code3, code2, code1, code0};
          idx_d     = '0;
          timeout_d = 1'b0;
          state_d   = S_SEL;
        end
      end
      S_SEL: begin
        if (idx_q == 3'd4) begin
          state_d = S_FIN;
        end else if (cur_code == SKIP_CODE) begin
          idx_d = idx_q + 3'd1;
        end else begin
          state_d = S_START_LO;
        end
      end
      S_START_LO: begin
        if (byte_done) begin
          state_d = S_ARM;
          cnt_d   = '0;
        end
      end
      S_ARM: begin
        if (cnt_q == ARM_LAST) begin
          state_d = S_WAIT_BUSY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_BUSY: begin
        if (busy_s_q) begin
          idx_d   = idx_q + 3'd1;
          state_d = S_SEL;
        end else if (cnt_q == TO_LAST) begin
          timeout_d = 1'b1;
          idx_d     = idx_q + 3'd1;
          state_d   = S_SEL;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      codes_q   <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      codes_q   <= codes_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign ready   = (state_q == S_IDLE);
  assign done    = (state_q == S_FIN);
  assign timeout = timeout_q;

endmodule
